// File: rtl/servant_mem_arbiter.sv
// Two-master Wishbone arbiter in front of a single memory port.
// Grants are round-robin or fixed-priority and are bounded by an ack timeout.
module servant_mem_arbiter #(
  parameter int TIMEOUT = 255,
  parameter bit RR      = 1'b1
) (
  input  logic        wb_clk,
  input  logic        wb_rst,
  input  logic [31:0] i_wb_m0_adr,
  input  logic [31:0] i_wb_m0_dat,
  input  logic [3:0]  i_wb_m0_sel,
  input  logic        i_wb_m0_we,
  input  logic        i_wb_m0_cyc,
  output logic [31:0] o_wb_m0_rdt,
  output logic        o_wb_m0_ack,
  input  logic [31:0] i_wb_m1_adr,
  input  logic [31:0] i_wb_m1_dat,
  input  logic [3:0]  i_wb_m1_sel,
  input  logic        i_wb_m1_we,
  input  logic        i_wb_m1_cyc,
  output logic [31:0] o_wb_m1_rdt,
  output logic        o_wb_m1_ack,
  output logic [31:0] o_wb_mem_adr,
  output logic [31:0] o_wb_mem_dat,
  output logic [3:0]  o_wb_mem_sel,
  output logic        o_wb_mem_we,
  output logic        o_wb_mem_cyc,
  input  logic [31:0] i_wb_mem_rdt,
  input  logic        i_wb_mem_ack,
  output logic        o_busy,
  output logic        o_timeout
);

  typedef enum logic [1:0] {IDLE, GNT0, GNT1} state_t;

  state_t      state, state_nx;
  logic        last_m1;
  logic [15:0] cnt;
  logic        g0, g1, cyc_sel, to_hit;

  always_comb begin
    g0      = (state == GNT0);
    g1      = (state == GNT1);
    cyc_sel = (g0 & i_wb_m0_cyc) | (g1 & i_wb_m1_cyc);
    // A real ack in the deadline cycle wins; an aborting master gets no forced ack.
    to_hit  = cyc_sel & ~i_wb_mem_ack & (cnt == 16'(TIMEOUT - 1));
  end

  always_comb begin
    o_wb_mem_adr = g0 ? i_wb_m0_adr : g1 ? i_wb_m1_adr : 32'd0;
    o_wb_mem_dat = g0 ? i_wb_m0_dat : g1 ? i_wb_m1_dat : 32'd0;
    o_wb_mem_sel = g0 ? i_wb_m0_sel : g1 ? i_wb_m1_sel : 4'd0;
    o_wb_mem_we  = (g0 & i_wb_m0_we) | (g1 & i_wb_m1_we);
    o_wb_mem_cyc = cyc_sel & ~to_hit;
    o_wb_m0_ack  = g0 & (i_wb_mem_ack | to_hit);
    o_wb_m1_ack  = g1 & (i_wb_mem_ack | to_hit);
    o_wb_m0_rdt  = (g0 & i_wb_mem_ack) ? i_wb_mem_rdt : 32'd0;
    o_wb_m1_rdt  = (g1 & i_wb_mem_ack) ? i_wb_mem_rdt : 32'd0;
    o_busy       = g0 | g1;
    o_timeout    = to_hit;
  end

  always_comb begin
    state_nx = state;
    case (state)
      IDLE: begin
        if (i_wb_m0_cyc && i_wb_m1_cyc)
          state_nx = (RR && !last_m1) ? GNT1 : GNT0;
        else if (i_wb_m0_cyc)
          state_nx = GNT0;
        else if (i_wb_m1_cyc)
          state_nx = GNT1;
      end
      GNT0, GNT1: begin
        if (i_wb_mem_ack || !cyc_sel || to_hit)
          state_nx = IDLE;
      end
      default: state_nx = IDLE;
    endcase
  end

  // last_m1 resets high so m0 takes the first tie.
  always_ff @(posedge wb_clk or posedge wb_rst) begin
    if (wb_rst) begin
      state   <= IDLE;
      cnt     <= 16'd0;
      last_m1 <= 1'b1;
    end else begin
      state <= state_nx;
      if (state == IDLE && state_nx != IDLE) begin
        cnt     <= 16'd0;
        last_m1 <= (state_nx == GNT1);
      end else if (o_busy && !i_wb_mem_ack) begin
        cnt <= cnt + 16'd1;
      end
    end
  end

endmodule

// File: tb/tb_servant_mem_arbiter.sv
// Directed bench: dut_a (RR=1) and dut_b (RR=0) share stimulus, both TIMEOUT=4.
// Inputs change #1 after a rising edge; outputs are checked #1 later.
module tb_servant_mem_arbiter;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] m0_adr, m0_dat, m1_adr, m1_dat, mem_rdt;
  logic [3:0]  m0_sel, m1_sel;
  logic        m0_we, m0_cyc, m1_we, m1_cyc, mem_ack;

  logic [31:0] a_m0_rdt, a_m1_rdt, a_mem_adr, a_mem_dat;
  logic [3:0]  a_mem_sel;
  logic        a_m0_ack, a_m1_ack, a_mem_we, a_mem_cyc, a_busy, a_to;
  logic [31:0] b_m0_rdt, b_m1_rdt, b_mem_adr, b_mem_dat;
  logic [3:0]  b_mem_sel;
  logic        b_m0_ack, b_m1_ack, b_mem_we, b_mem_cyc, b_busy, b_to;

  int n_chk = 0;
  int n_pass = 0;

  always #5 clk = ~clk;

  servant_mem_arbiter #(.TIMEOUT(4), .RR(1'b1)) dut_a (
    .wb_clk(clk), .wb_rst(rst),
    .i_wb_m0_adr(m0_adr), .i_wb_m0_dat(m0_dat), .i_wb_m0_sel(m0_sel),
    .i_wb_m0_we(m0_we), .i_wb_m0_cyc(m0_cyc),
    .o_wb_m0_rdt(a_m0_rdt), .o_wb_m0_ack(a_m0_ack),
    .i_wb_m1_adr(m1_adr), .i_wb_m1_dat(m1_dat), .i_wb_m1_sel(m1_sel),
    .i_wb_m1_we(m1_we), .i_wb_m1_cyc(m1_cyc),
    .o_wb_m1_rdt(a_m1_rdt), .o_wb_m1_ack(a_m1_ack),
    .o_wb_mem_adr(a_mem_adr), .o_wb_mem_dat(a_mem_dat), .o_wb_mem_sel(a_mem_sel),
    .o_wb_mem_we(a_mem_we), .o_wb_mem_cyc(a_mem_cyc),
    .i_wb_mem_rdt(mem_rdt), .i_wb_mem_ack(mem_ack),
    .o_busy(a_busy), .o_timeout(a_to)
  );

  servant_mem_arbiter #(.TIMEOUT(4), .RR(1'b0)) dut_b (
    .wb_clk(clk), .wb_rst(rst),
    .i_wb_m0_adr(m0_adr), .i_wb_m0_dat(m0_dat), .i_wb_m0_sel(m0_sel),
    .i_wb_m0_we(m0_we), .i_wb_m0_cyc(m0_cyc),
    .o_wb_m0_rdt(b_m0_rdt), .o_wb_m0_ack(b_m0_ack),
    .i_wb_m1_adr(m1_adr), .i_wb_m1_dat(m1_dat), .i_wb_m1_sel(m1_sel),
    .i_wb_m1_we(m1_we), .i_wb_m1_cyc(m1_cyc),
    .o_wb_m1_rdt(b_m1_rdt), .o_wb_m1_ack(b_m1_ack),
    .o_wb_mem_adr(b_mem_adr), .o_wb_mem_dat(b_mem_dat), .o_wb_mem_sel(b_mem_sel),
    .o_wb_mem_we(b_mem_we), .o_wb_mem_cyc(b_mem_cyc),
    .i_wb_mem_rdt(mem_rdt), .i_wb_mem_ack(mem_ack),
    .o_busy(b_busy), .o_timeout(b_to)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic settle;
    #1;
  endtask

  task automatic clr_inputs;
    m0_adr = 0; m0_dat = 0; m0_sel = 0; m0_we = 0; m0_cyc = 0;
    m1_adr = 0; m1_dat = 0; m1_sel = 0; m1_we = 0; m1_cyc = 0;
    mem_rdt = 0; mem_ack = 0;
  endtask

  task automatic do_reset;
    rst = 1'b1;
    clr_inputs();
    tick();
    rst = 1'b0;
  endtask

  initial begin
    rst = 1'b1;
    clr_inputs();
    tick(); tick();
    settle();
    chk("rst_busy", a_busy, 0);
    chk("rst_mem_cyc", a_mem_cyc, 0);

    // Single m0 read, memory acks on the third grant cycle.
    rst = 1'b0;
    m0_adr = 32'h100; m0_sel = 4'hF; m0_cyc = 1;
    settle();
    chk("idle_mem_adr", a_mem_adr, 0);
    chk("idle_mem_cyc", a_mem_cyc, 0);
    tick(); settle();
    chk("rd_busy1", a_busy, 1);
    chk("rd_mem_adr", a_mem_adr, 32'h100);
    chk("rd_mem_cyc", a_mem_cyc, 1);
    chk("rd_ack_early", a_m0_ack, 0);
    tick(); settle();
    chk("rd_busy2", a_busy, 1);
    tick();
    mem_ack = 1; mem_rdt = 32'hCAFEF00D;
    settle();
    chk("rd_busy3", a_busy, 1);
    chk("rd_m0_ack", a_m0_ack, 1);
    chk("rd_m0_rdt", a_m0_rdt, 32'hCAFEF00D);
    chk("rd_m1_ack", a_m1_ack, 0);
    chk("rd_m1_rdt", a_m1_rdt, 0);
    tick();
    mem_ack = 0; m0_cyc = 0;
    settle();
    chk("rd_busy_after", a_busy, 0);

    // Round-robin tie after reset: m0, bubble, m1, then m0 again.
    do_reset();
    m0_adr = 32'hA0; m1_adr = 32'hB0; m0_cyc = 1; m1_cyc = 1;
    tick(); settle();
    chk("rr_first_adr", a_mem_adr, 32'hA0);
    mem_ack = 1; mem_rdt = 32'h1;
    settle();
    chk("rr_m0_ack", a_m0_ack, 1);
    chk("rr_m1_ack_off", a_m1_ack, 0);
    tick();
    mem_ack = 0; m0_cyc = 0;
    settle();
    chk("rr_bubble", a_busy, 0);
    tick(); settle();
    chk("rr_second_adr", a_mem_adr, 32'hB0);
    mem_ack = 1;
    settle();
    chk("rr_m1_ack", a_m1_ack, 1);
    chk("rr_m0_ack_off", a_m0_ack, 0);
    tick();
    mem_ack = 0; m0_cyc = 1;
    tick(); settle();
    chk("rr_third_adr", a_mem_adr, 32'hA0);
    m0_cyc = 0; m1_cyc = 0;

    // Fixed priority: three back-to-back requests each, all m0 first.
    do_reset();
    m0_adr = 32'h200; m1_adr = 32'h300; m0_cyc = 1; m1_cyc = 1;
    for (int i = 0; i < 6; i++) begin
      tick(); settle();
      chk($sformatf("fp_adr%0d", i), b_mem_adr, (i < 3) ? 32'h200 : 32'h300);
      mem_ack = 1;
      settle();
      chk($sformatf("fp_m0ack%0d", i), b_m0_ack, (i < 3) ? 1 : 0);
      chk($sformatf("fp_m1ack%0d", i), b_m1_ack, (i < 3) ? 0 : 1);
      tick();
      mem_ack = 0;
      if (i == 2) m0_cyc = 0;
      if (i == 5) m1_cyc = 0;
      settle();
      chk($sformatf("fp_bubble%0d", i), b_busy, 0);
    end

    // Timeout on the 4th grant cycle; a late ack afterwards is ignored.
    do_reset();
    m0_adr = 32'h400; m0_cyc = 1; mem_rdt = 32'hDEADBEEF;
    tick(); settle();
    chk("to_g1_pulse", a_to, 0);
    tick(); tick(); settle();
    chk("to_g3_ack", a_m0_ack, 0);
    tick(); settle();
    chk("to_g4_ack", a_m0_ack, 1);
    chk("to_g4_rdt", a_m0_rdt, 0);
    chk("to_g4_mem_cyc", a_mem_cyc, 0);
    chk("to_g4_pulse", a_to, 1);
    tick();
    m0_cyc = 0;
    settle();
    chk("to_pulse_end", a_to, 0);
    chk("to_idle", a_busy, 0);
    tick(); tick();
    mem_ack = 1;
    settle();
    chk("late_ack_m0", a_m0_ack, 0);
    tick(); settle();
    chk("late_ack_state", a_busy, 0);
    mem_ack = 0;

    // Ack exactly on the deadline cycle beats the timeout.
    m0_cyc = 1;
    tick(); tick(); tick(); tick();
    mem_ack = 1; mem_rdt = 32'h12345678;
    settle();
    chk("dl_ack", a_m0_ack, 1);
    chk("dl_rdt", a_m0_rdt, 32'h12345678);
    chk("dl_pulse", a_to, 0);
    tick();
    mem_ack = 0; m0_cyc = 0;

    // Master abort: cyc drops mid-grant, no ack.
    m0_cyc = 1;
    tick();
    m0_cyc = 0;
    settle();
    chk("abort_mem_cyc", a_mem_cyc, 0);
    chk("abort_ack", a_m0_ack, 0);
    tick(); settle();
    chk("abort_idle", a_busy, 0);

    // Reset in the middle of an m1 write, then regrant.
    m1_adr = 32'h500; m1_dat = 32'h55AA55AA; m1_sel = 4'hF; m1_we = 1; m1_cyc = 1;
    tick(); settle();
    chk("wr_mem_we", a_mem_we, 1);
    chk("wr_mem_sel", a_mem_sel, 4'hF);
    chk("wr_mem_dat", a_mem_dat, 32'h55AA55AA);
    rst = 1; mem_ack = 1;
    settle();
    chk("wr_rst_cyc", a_mem_cyc, 0);
    chk("wr_rst_ack", a_m1_ack, 0);
    tick();
    rst = 0; mem_ack = 0;
    settle();
    chk("wr_post_idle", a_busy, 0);
    tick(); settle();
    chk("wr_regrant", a_busy, 1);
    chk("wr_regrant_adr", a_mem_adr, 32'h500);
    mem_ack = 1;
    settle();
    chk("wr_regrant_ack", a_m1_ack, 1);
    tick();
    clr_inputs();

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule

// File: doc/servant_mem_arbiter.md
SERVANT_MEM_ARBITER -- requirements
Module: servant_mem_arbiter

Interface
REQ-001 SHALL have parameter TIMEOUT, default 255, meaning the maximum number of cycles a granted transfer waits for slave ack (1..65535).
REQ-002 SHALL have parameter RR, default 1, meaning round-robin priority when 1 and fixed priority (m0 wins) when 0.
REQ-003 wb_clk  in  1  the only clock; all state changes on its rising edge.
REQ-004 wb_rst  in  1  reset, asynchronous and active-high.
REQ-005 i_wb_m0_adr/dat  in  32 each; i_wb_m0_sel  in  4; i_wb_m0_we, i_wb_m0_cyc  in  1  master 0 request.
REQ-006 o_wb_m0_rdt  out  32; o_wb_m0_ack  out  1  master 0 response.
REQ-007 i_wb_m1_adr/dat  in  32 each; i_wb_m1_sel  in  4; i_wb_m1_we, i_wb_m1_cyc  in  1  master 1 request.
REQ-008 o_wb_m1_rdt  out  32; o_wb_m1_ack  out  1  master 1 response.
REQ-009 o_wb_mem_adr/dat  out  32 each; o_wb_mem_sel  out  4; o_wb_mem_we, o_wb_mem_cyc  out  1  shared memory port.
REQ-010 i_wb_mem_rdt  in  32; i_wb_mem_ack  in  1  memory response.
REQ-011 o_busy  out  1  high while any grant is active; o_timeout  out  1  one-cycle pulse on transfer abort.

Function
REQ-012 SHALL implement FSM states IDLE, GNT0, GNT1.
REQ-013 In IDLE, SHALL grant on the next edge: only m0 cyc -> GNT0; only m1 cyc -> GNT1; both -> the master not granted last (RR=1) or m0 (RR=0); neither -> stay IDLE.
REQ-014 The last-granted pointer SHALL update on entry to GNT0/GNT1; after reset it SHALL point to m1 so m0 wins the first tie.
REQ-015 In GNTn, o_wb_mem_adr/dat/sel/we SHALL equal master n's inputs combinationally, and o_wb_mem_cyc SHALL equal i_wb_mn_cyc.
REQ-016 Outside GNTn, all o_wb_mem_* SHALL be 0.
REQ-017 In GNTn, o_wb_mn_ack SHALL equal i_wb_mem_ack, and o_wb_mn_rdt SHALL equal i_wb_mem_rdt.
REQ-018 The non-granted master SHALL see ack=0 and rdt=0.
REQ-019 On i_wb_mem_ack high in GNTn, the FSM SHALL return to IDLE at that edge; a new grant SHALL therefore take at least one IDLE cycle (minimum 1-cycle bubble between transfers).
REQ-020 If i_wb_mn_cyc drops in GNTn without ack (master abort), SHALL return to IDLE next edge with no ack issued.
REQ-021 A 16-bit wait counter SHALL clear on entry to GNTn and increment every GNTn cycle without ack.
REQ-022 When the counter equals TIMEOUT-1 and ack is still low, the arbiter SHALL, in that cycle, force o_wb_mn_ack=1, o_wb_mn_rdt=0, o_wb_mem_cyc=0, and o_timeout=1, then go to IDLE.
REQ-023 Ack arriving in the same cycle as the timeout SHALL take precedence: normal ack and rdt, no o_timeout.
REQ-024 i_wb_mem_ack while in IDLE (late ack after timeout) SHALL be ignored: no master ack, no state change.
REQ-025 A request arriving during GNTn from the other master SHALL be held pending (its cyc stays high) and granted from IDLE by REQ-013 rules.
REQ-026 o_busy SHALL be 1 exactly in GNT0/GNT1.

Reset
REQ-027 Asserting wb_rst at any time, including mid-transfer, SHALL immediately force IDLE, counter=0, pointer=m1, and all outputs 0; no ack SHALL be issued for the interrupted transfer.
REQ-028 After wb_rst deasserts, the first grant SHALL occur no earlier than the first rising edge with wb_rst low.

Verification
REQ-029 m0 read adr=0x100; memory acks 2 cycles after o_wb_mem_cyc with rdt=0xCAFEF00D -> m0 ack 1 cycle, rdt=0xCAFEF00D; m1 ack=0; o_busy high for 3 cycles.
REQ-030 m0 and m1 cyc rise on the same cycle after reset, RR=1 -> m0 granted first; after its ack and 1 IDLE cycle m1 granted; on the next tie m0 wins again.
REQ-031 RR=0, both masters issue 3 back-to-back requests each -> all m0 transfers complete before any m1 grant.
REQ-032 TIMEOUT=4, memory never acks -> on the 4th GNT cycle m0 sees ack=1, rdt=0, o_timeout one-cycle pulse; a memory ack 2 cycles later is ignored.
REQ-033 TIMEOUT=4, memory acks exactly on the 4th GNT cycle with rdt=0x12345678 -> normal ack, rdt=0x12345678, o_timeout stays 0.
REQ-034 wb_rst asserted mid-GNT1 write (sel=0xF) -> o_wb_mem_cyc=0 asynchronously, no m1 ack; after release, m1 cyc still high -> regranted after 1 IDLE cycle.
